wb_arbiter: RTL and testbench

Writeback arbiter between the functional units and the reorder buffer's finish port. Each of NUM_REQ completion sources posts a result {uid, val, loc} into its own one-entry holding slot. Each cycle the arbiter grants up to GRANTS buffered results in round-robin order and drives them, registered, as the lanes of the ROB's per-cycle finishing list. `flush_all` discards everything in flight.

---
 rtl/wb_arbiter_if.sv | 33 +++
 rtl/wb_arbiter.sv | 121 ++++++++++++
 tb/tb_wb_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Completion-source and writeback-lane bundle for wb_arbiter.
// slave = arbiter side, master = sources/ROB side.
interface wb_arbiter_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned GRANTS   = 2,
  parameter int unsigned UID_BITS = 3,
  parameter int unsigned VAL_W    = 16,
  parameter int unsigned LOC_W    = 18
);
  localparam int unsigned CNT_W = $clog2(GRANTS + 1);

  logic                         flush_all;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*UID_BITS-1:0]  req_uid;
  logic [NUM_REQ*VAL_W-1:0]     req_val;
  logic [NUM_REQ*LOC_W-1:0]     req_loc;
  logic [GRANTS-1:0]            wb_valid;
  logic [GRANTS*UID_BITS-1:0]   wb_uid;
  logic [GRANTS*VAL_W-1:0]      wb_val;
  logic [GRANTS*LOC_W-1:0]      wb_loc;
  logic [CNT_W-1:0]             wb_count;

  modport slave (
    input  flush_all, req_valid, req_uid, req_val, req_loc,
    output req_ready, wb_valid, wb_uid, wb_val, wb_loc, wb_count
  );

  modport master (
    output flush_all, req_valid, req_uid, req_val, req_loc,
    input  req_ready, wb_valid, wb_uid, wb_val, wb_loc, wb_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: one holding slot per completion source,
// up to GRANTS results per cycle registered onto the ROB finish lanes.
module wb_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned GRANTS   = 2,
  parameter int unsigned UID_BITS = 3,
  parameter int unsigned VAL_W    = 16,
  parameter int unsigned LOC_W    = 18
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(GRANTS + 1);

  logic [NUM_REQ-1:0]     buf_v;
  logic [UID_BITS-1:0]    buf_uid [NUM_REQ];
  logic [VAL_W-1:0]       buf_val [NUM_REQ];
  logic [LOC_W-1:0]       buf_loc [NUM_REQ];
  logic [PTR_W-1:0]       rr_ptr;

  logic [PTR_W-1:0]       rr_next;
  logic [PTR_W-1:0]       last_idx;
  logic [PTR_W-1:0]       idx;
  int unsigned            pos;
  logic [NUM_REQ-1:0]     granted;
  logic [CNT_W-1:0]       n_grant;
  logic [PTR_W-1:0]       lane_src [GRANTS];

  logic [GRANTS-1:0]          lane_v;
  logic [GRANTS*UID_BITS-1:0] lane_uid;
  logic [GRANTS*VAL_W-1:0]    lane_val;
  logic [GRANTS*LOC_W-1:0]    lane_loc;

  // Circular scan from rr_ptr; the k-th valid slot found drives lane k.
  always_comb begin
    granted  = '0;
    n_grant  = '0;
    last_idx = rr_ptr;
    pos      = 0;
    idx      = '0;
    for (int k = 0; k < GRANTS; k++) lane_src[k] = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      pos = 32'(rr_ptr) + 32'(j);
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = PTR_W'(pos);
      if (buf_v[idx] && (n_grant < CNT_W'(GRANTS))) begin
        granted[idx] = 1'b1;
        for (int k = 0; k < GRANTS; k++) begin
          if (n_grant == CNT_W'(k)) lane_src[k] = idx;
        end
        n_grant  = n_grant + CNT_W'(1);
        last_idx = idx;
      end
    end
    rr_next = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
  end

  always_comb begin
    lane_v   = '0;
    lane_uid = '0;
    lane_val = '0;
    lane_loc = '0;
    for (int k = 0; k < GRANTS; k++) begin
      if (CNT_W'(k) < n_grant) begin
        lane_v[k]                          = 1'b1;
        lane_uid[k*UID_BITS +: UID_BITS]   = buf_uid[lane_src[k]];
        lane_val[k*VAL_W +: VAL_W]         = buf_val[lane_src[k]];
        lane_loc[k*LOC_W +: LOC_W]         = buf_loc[lane_src[k]];
      end
    end
  end

  // A slot being drained this cycle can take a new result in the same edge.
  always_comb begin
    bus.req_ready = bus.flush_all ? '0 : (~buf_v | granted);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_v        <= '0;
      rr_ptr       <= '0;
      bus.wb_valid <= '0;
      bus.wb_uid   <= '0;
      bus.wb_val   <= '0;
      bus.wb_loc   <= '0;
      bus.wb_count <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_uid[i] <= '0;
        buf_val[i] <= '0;
        buf_loc[i] <= '0;
      end
    end else if (bus.flush_all) begin
      buf_v        <= '0;
      rr_ptr       <= '0;
      bus.wb_valid <= '0;
      bus.wb_uid   <= '0;
      bus.wb_val   <= '0;
      bus.wb_loc   <= '0;
      bus.wb_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          buf_v[i]   <= 1'b1;
          buf_uid[i] <= bus.req_uid[i*UID_BITS +: UID_BITS];
          buf_val[i] <= bus.req_val[i*VAL_W +: VAL_W];
          buf_loc[i] <= bus.req_loc[i*LOC_W +: LOC_W];
        end else if (granted[i]) begin
          buf_v[i] <= 1'b0;
        end
      end
      if (n_grant != '0) rr_ptr <= rr_next;
      bus.wb_valid <= lane_v;
      bus.wb_uid   <= lane_uid;
      bus.wb_val   <= lane_val;
      bus.wb_loc   <= lane_loc;
      bus.wb_count <= n_grant;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed stimulus pushes hand-computed
// lane bundles; a negedge monitor pops and compares every valid output.
module tb_wb_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned G  = 2;
  localparam int unsigned UB = 3;
  localparam int unsigned VW = 16;
  localparam int unsigned LW = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if #(.NUM_REQ(NR), .GRANTS(G), .UID_BITS(UB), .VAL_W(VW), .LOC_W(LW)) bus ();

  wb_arbiter #(.NUM_REQ(NR), .GRANTS(G), .UID_BITS(UB), .VAL_W(VW), .LOC_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [G-1:0]    v;
    logic [1:0]      cnt;
    logic [G*UB-1:0] uid;
    logic [G*VW-1:0] val;
    logic [G*LW-1:0] loc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   last_out = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [2:0]  puid(input int i, input int n); return 3'(i + 4*n); endfunction
  function automatic logic [15:0] pval(input int i, input int n); return 16'(4096*i + 17*n); endfunction
  function automatic logic [17:0] ploc(input int i, input int n); return 18'(i*65536 + n); endfunction

  task automatic push1(input logic [2:0] u, input logic [15:0] v, input logic [17:0] l);
    exp_t e;
    e.v = 2'b01; e.cnt = 2'd1;
    e.uid = {3'd0, u}; e.val = {16'd0, v}; e.loc = {18'd0, l};
    sbq.push_back(e);
  endtask

  task automatic push2(input logic [2:0] u0, input logic [15:0] v0, input logic [17:0] l0,
                       input logic [2:0] u1, input logic [15:0] v1, input logic [17:0] l1);
    exp_t e;
    e.v = 2'b11; e.cnt = 2'd2;
    e.uid = {u1, u0}; e.val = {v1, v0}; e.loc = {l1, l0};
    sbq.push_back(e);
  endtask

  task automatic push_src2(input int i0, input int i1, input int n);
    push2(puid(i0, n), pval(i0, n), ploc(i0, n), puid(i1, n), pval(i1, n), ploc(i1, n));
  endtask

  task automatic drive_raw(input int i, input logic [2:0] u, input logic [15:0] v, input logic [17:0] l);
    bus.req_valid[i]         = 1'b1;
    bus.req_uid[i*UB +: UB]  = u;
    bus.req_val[i*VW +: VW]  = v;
    bus.req_loc[i*LW +: LW]  = l;
  endtask

  task automatic drive_src(input int i, input int n);
    drive_raw(i, puid(i, n), pval(i, n), ploc(i, n));
  endtask

  task automatic idle();
    bus.flush_all = 1'b0;
    bus.req_valid = '0;
    bus.req_uid   = '0;
    bus.req_val   = '0;
    bus.req_loc   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.wb_valid !== '0) begin
      last_out = cyc;
      if (sbq.size() == 0) begin
        check("unexpected_wb_valid", 64'(bus.wb_valid), 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("wb_valid", 64'(bus.wb_valid), 64'(mon_e.v));
        check("wb_count", 64'(bus.wb_count), 64'(mon_e.cnt));
        check("wb_uid",   64'(bus.wb_uid),   64'(mon_e.uid));
        check("wb_val",   64'(bus.wb_val),   64'(mon_e.val));
        check("wb_loc",   64'(bus.wb_loc),   64'(mon_e.loc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int s;
    int c;
    int items[4];
    logic [3:0] acc;
    logic [3:0] exp_rdy[5];
    exp_rdy = '{4'b1111, 4'b0011, 4'b1100, 4'b0011, 4'b1100};

    // Reset state
    idle();
    tick();
    tick();
    check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("rst_wb_count", 64'(bus.wb_count), 64'd0);
    check("rst_wb_payload", 64'({bus.wb_uid, bus.wb_val}), 64'd0);
    check("rst_wb_loc", 64'(bus.wb_loc), 64'd0);
    check("rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", 64'(bus.req_ready), 64'hF);

    // Single source, single result
    tick();
    push1(3'd5, 16'h1234, 18'd0);
    drive_raw(1, 3'd5, 16'h1234, 18'd0);
    tick();
    idle();
    tick();
    check("single_rr_ptr", 64'(dut.rr_ptr), 64'd2);
    tick();
    tick();
    check("single_sb_empty", 64'(sbq.size()), 64'd0);

    // All four sources streaming, three results each
    apply_reset();
    s = cyc;
    for (int m = 0; m < 6; m++) begin
      if (m % 2 == 0) push_src2(0, 1, m / 2);
      else            push_src2(2, 3, m / 2);
    end
    items = '{default: 0};
    c = 0;
    while ((items[0] < 3 || items[1] < 3 || items[2] < 3 || items[3] < 3) && c < 20) begin
      for (int i = 0; i < 4; i++) begin
        if (items[i] < 3) drive_src(i, items[i]);
        else bus.req_valid[i] = 1'b0;
      end
      @(negedge clk);
      if (c < 5) check($sformatf("stream_ready_c%0d", c), 64'(bus.req_ready), 64'(exp_rdy[c]));
      acc = bus.req_valid & bus.req_ready;
      tick();
      for (int i = 0; i < 4; i++) if (acc[i]) items[i]++;
      c++;
    end
    check("stream_accept_cycles", 64'(c), 64'd5);
    idle();
    tick();
    tick();
    tick();
    check("stream_sb_empty", 64'(sbq.size()), 64'd0);
    check("stream_last_out", 64'(last_out - s), 64'd7);

    // Wrap-around: rr_ptr=3 with slots 3 and 0 valid
    apply_reset();
    push1(3'd2, 16'h0202, 18'h10000);
    push2(3'd3, 16'h0303, 18'h20000, 3'd6, 16'h0a0a, 18'h30000);
    drive_raw(2, 3'd2, 16'h0202, 18'h10000);
    tick();
    idle();
    drive_raw(3, 3'd3, 16'h0303, 18'h20000);
    drive_raw(0, 3'd6, 16'h0a0a, 18'h30000);
    tick();
    idle();
    check("wrap_rr_before", 64'(dut.rr_ptr), 64'd3);
    tick();
    check("wrap_rr_after", 64'(dut.rr_ptr), 64'd1);
    tick();
    tick();
    check("wrap_sb_empty", 64'(sbq.size()), 64'd0);

    // Same-cycle drain and refill on source 2
    apply_reset();
    s = cyc;
    for (int n = 1; n <= 3; n++) push1(3'(n), 16'(16'hA000 + n), 18'd0);
    for (int n = 1; n <= 3; n++) begin
      drive_raw(2, 3'(n), 16'(16'hA000 + n), 18'd0);
      @(negedge clk);
      check($sformatf("refill_ready_%0d", n), 64'(bus.req_ready), 64'hF);
      tick();
    end
    idle();
    tick();
    tick();
    tick();
    check("refill_sb_empty", 64'(sbq.size()), 64'd0);
    check("refill_last_out", 64'(last_out - s), 64'd4);

    // Flush mid-stream
    apply_reset();
    push_src2(0, 1, 0);
    for (int i = 0; i < 4; i++) drive_src(i, 0);
    tick();
    drive_src(0, 1);
    drive_src(1, 1);
    tick();
    check("flush_pre_wb_valid", 64'(bus.wb_valid), 64'h3);
    bus.flush_all = 1'b1;
    for (int i = 0; i < 4; i++) drive_src(i, 2);
    #1;
    check("flush_ready", 64'(bus.req_ready), 64'd0);
    tick();
    idle();
    check("flush_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("flush_wb_count", 64'(bus.wb_count), 64'd0);
    check("flush_buf_v", 64'(dut.buf_v), 64'd0);
    check("flush_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    tick();
    tick();
    tick();
    check("flush_sb_empty", 64'(sbq.size()), 64'd0);

    // Asynchronous reset with results pending
    apply_reset();
    for (int i = 0; i < 4; i++) drive_src(i, 0);
    tick();
    idle();
    tick();
    check("arst_pre_wb_valid", 64'(bus.wb_valid), 64'h3);
    check("arst_pre_wb_count", 64'(bus.wb_count), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("arst_wb_count", 64'(bus.wb_count), 64'd0);
    check("arst_buf_v", 64'(dut.buf_v), 64'd0);
    check("arst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("arst_ready", 64'(bus.req_ready), 64'hF);
    tick();
    tick();
    check("final_sb_empty", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
